// File: rtl/block_average_scaler.sv
// Frame downscaler: each output pixel is the mean of an NxN source block (N = 1<<zoom_shift),
// read from a synchronous source RAM and written linearly to the output buffer.
module block_average_scaler #(
   parameter int IMG_W     = 160,
   parameter int IMG_H     = 120,
   parameter int PIX_W     = 8,
   parameter int RA_W      = 15,
   parameter int WA_W      = 15,
   parameter int RD_LAT    = 1,
   parameter int MAX_SHIFT = 2,
   parameter int ROUND     = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       zoom_shift,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [RA_W-1:0]  rd_addr,
   output logic             rd_en,
   input  logic [PIX_W-1:0] rd_data,
   output logic [WA_W-1:0]  wr_addr,
   output logic [PIX_W-1:0] wr_data,
   output logic             wr_en
);

   localparam int AW = PIX_W + 2*MAX_SHIFT;
   localparam int SW = AW + 1;
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int DW = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;
   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, FIN} state_t;

   state_t            state, state_nx;
   logic [1:0]        s;
   logic [XW-1:0]     ox, ox_last;
   logic [YW-1:0]     oy, oy_last;
   logic [DW-1:0]     dx, dy, n_m1;
   logic [LW-1:0]     dcnt;
   logic [AW-1:0]     acc;
   logic [RD_LAT-1:0] vld;
   logic [RA_W-1:0]   rd_addr_q, rd_addr_c, row_c;
   logic [WA_W-1:0]   wr_addr_q, wr_addr_c;
   logic [PIX_W-1:0]  wr_data_q, wr_data_c;
   logic [SW-1:0]     sum_c, quo_c;
   logic              start_ok, start_bad, last_sample, last_pix;

   assign start_ok    = start && (32'(zoom_shift) <= MAX_SHIFT);
   assign start_bad   = start && !start_ok;
   assign n_m1        = DW'((32'd1 << s) - 32'd1);
   assign ox_last     = XW'((IMG_W >> s) - 1);
   assign oy_last     = YW'((IMG_H >> s) - 1);
   assign last_sample = (dx == n_m1) && (dy == n_m1);
   assign last_pix    = (ox == ox_last) && (oy == oy_last);

   always_comb begin
      row_c     = (RA_W'(oy) << s) + RA_W'(dy);
      rd_addr_c = row_c * RA_W'(IMG_W) + (RA_W'(ox) << s) + RA_W'(dx);
      wr_addr_c = WA_W'(oy) * (WA_W'(IMG_W) >> s) + WA_W'(ox);
      sum_c     = {1'b0, acc};
      if (ROUND != 0 && s != 2'd0)
         sum_c = sum_c + (SW'(1) << ({s, 1'b0} - 3'd1));
      quo_c     = sum_c >> {s, 1'b0};
      wr_data_c = (quo_c > SW'({PIX_W{1'b1}})) ? '1 : quo_c[PIX_W-1:0];
   end

   // Addresses and data are only driven live while their strobe is high; otherwise the last value holds.
   assign rd_en   = (state == FETCH);
   assign wr_en   = (state == WRITE);
   assign busy    = (state == FETCH) || (state == DRAIN) || (state == WRITE);
   assign done    = (state == FIN);
   assign rd_addr = rd_en ? rd_addr_c : rd_addr_q;
   assign wr_addr = wr_en ? wr_addr_c : wr_addr_q;
   assign wr_data = wr_en ? wr_data_c : wr_data_q;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_ok) state_nx = FETCH;
                  else if (start_bad) state_nx = FIN;
         FETCH:   if (last_sample) state_nx = DRAIN;
         DRAIN:   if (dcnt == LW'(RD_LAT - 1)) state_nx = WRITE;
         WRITE:   state_nx = last_pix ? FIN : FETCH;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         s         <= '0;
         ox        <= '0;
         oy        <= '0;
         dx        <= '0;
         dy        <= '0;
         dcnt      <= '0;
         acc       <= '0;
         vld       <= '0;
         err       <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state     <= state_nx;
         vld       <= RD_LAT'({vld, rd_en});
         rd_addr_q <= rd_addr;
         wr_addr_q <= wr_addr;
         wr_data_q <= wr_data;
         if (vld[RD_LAT-1])
            acc <= acc + AW'(rd_data);
         case (state)
            IDLE: begin
               if (start_ok) begin
                  s   <= zoom_shift;
                  ox  <= '0;
                  oy  <= '0;
                  dx  <= '0;
                  dy  <= '0;
                  acc <= '0;
                  err <= 1'b0;
               end else if (start_bad) begin
                  err <= 1'b1;
               end
            end
            FETCH: begin
               dcnt <= '0;
               if (dx == n_m1) begin
                  dx <= '0;
                  dy <= (dy == n_m1) ? '0 : dy + 1'b1;
               end else begin
                  dx <= dx + 1'b1;
               end
            end
            DRAIN: dcnt <= dcnt + 1'b1;
            WRITE: begin
               acc <= '0;
               if (ox == ox_last) begin
                  ox <= '0;
                  oy <= oy + 1'b1;
               end else begin
                  ox <= ox + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_block_average_scaler.sv
// Bench for block_average_scaler: three 8x4 instances (RD_LAT 1/3/2, ROUND 1/1/0) share stimulus,
// a 160x120 instance covers the full-size saturation case; writes are scoreboarded against a block-mean model.
module tb_block_average_scaler;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       start_b = 1'b0;
   logic [1:0] zoom = 2'd0;
   int         pattern = 0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         q0[$], q1[$], q2[$], q3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int src(input int pat, input int a);
      case (pat)
         0: return a & 255;
         1: return 255;
         2: begin
            if (a == 0) return 10;
            if (a == 1) return 11;
            if (a == 8) return 12;
            if (a == 9) return 13;
            return (a * 7) & 255;
         end
         default: return ((a * 73) ^ (a >> 2) ^ 8'h5A) & 255;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int qsize(input int k);
      case (k)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic void qpush(input int k, input int e);
      case (k)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endfunction

   function automatic int qpop(input int k);
      case (k)
         0: return q0.pop_front();
         1: return q1.pop_front();
         2: return q2.pop_front();
         default: return q3.pop_front();
      endcase
   endfunction

   task automatic sb_pop(input int k, input int a, input int d);
      int got;
      got = (a << 8) | d;
      if (qsize(k) == 0) chk("sb_unexpected_write", 64'(got), 64'hFFFF_FFFF);
      else chk("sb_write", 64'(got), 64'(qpop(k)));
   endtask

   task automatic push_frame(input int k, input int w, input int h, input int s, input bit rnd);
      int n, ow, oh, sum, v;
      n = 1 << s; ow = w >> s; oh = h >> s;
      for (int oy = 0; oy < oh; oy++)
         for (int ox = 0; ox < ow; ox++) begin
            sum = 0;
            for (int dy = 0; dy < n; dy++)
               for (int dx = 0; dx < n; dx++)
                  sum += src(pattern, (oy*n + dy)*w + ox*n + dx);
            if (rnd && s > 0) sum += 1 << (2*s - 1);
            v = sum >> (2*s);
            if (v > 255) v = 255;
            qpush(k, ((oy*ow + ox) << 8) | v);
         end
   endtask

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int W   = (g == 3) ? 160 : 8;
      localparam int H   = (g == 3) ? 120 : 4;
      localparam int LAT = (g == 1) ? 3 : (g == 2) ? 2 : 1;
      localparam int RND = (g == 2) ? 0 : 1;
      logic        busy, done, err, rd_en, wr_en;
      logic [14:0] rd_addr, wr_addr;
      logic [7:0]  rd_data, wr_data;
      logic [7:0]  dpipe [LAT];
      int          wr_cnt = 0, done_cnt = 0, rd_cnt = 0, done_cyc = 0, first_wd = -1;

      block_average_scaler #(.IMG_W(W), .IMG_H(H), .RD_LAT(LAT), .ROUND(RND)) u_dut (
         .clk(clk), .reset_n(reset_n), .start((g == 3) ? start_b : start), .zoom_shift(zoom),
         .busy(busy), .done(done), .err(err), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
         .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en));

      always @(posedge clk) begin
         dpipe[0] <= 8'(src(pattern, int'(rd_addr)));
         for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
      end
      assign rd_data = dpipe[LAT-1];

      always @(negedge clk) begin
         if (wr_en) begin
            wr_cnt++;
            if (wr_addr == 15'd0) first_wd = int'(wr_data);
            sb_pop(g, int'(wr_addr), int'(wr_data));
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (rd_en) rd_cnt++;
      end
   end

   function automatic void snap(input int k, output int w, output int d, output int r, output int dc);
      case (k)
         0: begin w = g_dut[0].wr_cnt; d = g_dut[0].done_cnt; r = g_dut[0].rd_cnt; dc = g_dut[0].done_cyc; end
         1: begin w = g_dut[1].wr_cnt; d = g_dut[1].done_cnt; r = g_dut[1].rd_cnt; dc = g_dut[1].done_cyc; end
         2: begin w = g_dut[2].wr_cnt; d = g_dut[2].done_cnt; r = g_dut[2].rd_cnt; dc = g_dut[2].done_cyc; end
         default: begin w = g_dut[3].wr_cnt; d = g_dut[3].done_cnt; r = g_dut[3].rd_cnt; dc = g_dut[3].done_cyc; end
      endcase
   endfunction

   function automatic logic [63:0] outs(input int k);
      case (k)
         0: return 64'({g_dut[0].busy, g_dut[0].done, g_dut[0].err, g_dut[0].rd_en, g_dut[0].wr_en,
                        g_dut[0].rd_addr, g_dut[0].wr_addr, g_dut[0].wr_data});
         1: return 64'({g_dut[1].busy, g_dut[1].done, g_dut[1].err, g_dut[1].rd_en, g_dut[1].wr_en,
                        g_dut[1].rd_addr, g_dut[1].wr_addr, g_dut[1].wr_data});
         2: return 64'({g_dut[2].busy, g_dut[2].done, g_dut[2].err, g_dut[2].rd_en, g_dut[2].wr_en,
                        g_dut[2].rd_addr, g_dut[2].wr_addr, g_dut[2].wr_data});
         default: return 64'({g_dut[3].busy, g_dut[3].done, g_dut[3].err, g_dut[3].rd_en, g_dut[3].wr_en,
                              g_dut[3].rd_addr, g_dut[3].wr_addr, g_dut[3].wr_data});
      endcase
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // One frame on the three 8x4 instances; repulse re-asserts start mid-frame with a different zoom.
   task automatic run_small(input int s, input int pat, input bit repulse);
      int w0[3], d0[3], r0[3], w, d, r, dc, st, n, p, nn, lat;
      bit valid;
      valid = (s <= 2);
      p  = valid ? (8 >> s) * (4 >> s) : 0;
      nn = valid ? (1 << s) * (1 << s) : 0;
      for (int k = 0; k < 3; k++) snap(k, w0[k], d0[k], r0[k], dc);
      pattern = pat;
      zoom = 2'(s);
      if (valid) begin
         push_frame(0, 8, 4, s, 1'b1);
         push_frame(1, 8, 4, s, 1'b1);
         push_frame(2, 8, 4, s, 1'b0);
      end
      @(posedge clk); #1 start = 1'b1; st = cyc;
      @(posedge clk); #1 start = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         chk("busy_after_start", 64'(outs(k)[42]), 64'(valid));
         chk("err_after_start", 64'(outs(k)[40]), 64'(!valid));
         chk("done_next_cycle", 64'(outs(k)[41]), 64'(!valid));
      end
      if (repulse) begin
         repeat (10) @(posedge clk);
         #1 zoom = 2'(s ^ 1); start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      n = 0;
      while (n < 5000 && (g_dut[0].done_cnt == d0[0] || g_dut[1].done_cnt == d0[1] ||
                          g_dut[2].done_cnt == d0[2])) begin
         tick();
         n++;
      end
      chk("done_wait_timeout", 64'(n >= 5000), 64'd0);
      repeat (6) tick();
      for (int k = 0; k < 3; k++) begin
         lat = (k == 1) ? 3 : (k == 2) ? 2 : 1;
         snap(k, w, d, r, dc);
         chk("done_count", 64'(d - d0[k]), 64'd1);
         chk("wr_count", 64'(w - w0[k]), 64'(p));
         chk("rd_count", 64'(r - r0[k]), 64'(p * nn));
         chk("frame_cycles", 64'(dc - st + 1), valid ? 64'(p * (nn + lat + 1) + 2) : 64'd2);
         chk("sb_left", 64'(qsize(k)), 64'd0);
      end
   endtask

   initial begin
      int w, d, r, dc, w0, d0, st, n;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) chk("reset_outputs", outs(k), 64'd0);

      run_small(0, 0, 1'b0);                // copy, ramp
      run_small(1, 2, 1'b0);                // 2x2, block {10,11,12,13}
      chk("round_half_up", 64'(g_dut[0].first_wd), 64'd12);
      chk("round_half_up_lat3", 64'(g_dut[1].first_wd), 64'd12);
      chk("truncate", 64'(g_dut[2].first_wd), 64'd11);
      run_small(2, 3, 1'b0);                // 4x4, scrambled source
      run_small(3, 0, 1'b0);                // illegal shift
      run_small(1, 0, 1'b0);                // valid start clears err

      pattern = 3; zoom = 2'd1;
      push_frame(0, 8, 4, 1, 1'b1);
      push_frame(1, 8, 4, 1, 1'b1);
      push_frame(2, 8, 4, 1, 1'b0);
      w0 = g_dut[0].wr_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      while (n < 2000 && g_dut[0].wr_cnt != w0 + 5) begin
         tick();
         n++;
      end
      chk("pixel5_wait_timeout", 64'(n >= 2000), 64'd0);
      @(posedge clk); #1 reset_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) chk("midframe_reset_outputs", outs(k), 64'd0);
      q0.delete(); q1.delete(); q2.delete();
      run_small(1, 3, 1'b0);                // full frame after abort
      run_small(1, 2, 1'b1);                // start while busy ignored

      pattern = 1; zoom = 2'd2;
      push_frame(3, 160, 120, 2, 1'b1);
      snap(3, w0, d0, r, dc);
      @(posedge clk); #1 start_b = 1'b1; st = cyc;
      @(posedge clk); #1 start_b = 1'b0;
      n = 0;
      while (n < 30000 && g_dut[3].done_cnt == d0) begin
         tick();
         n++;
      end
      chk("big_wait_timeout", 64'(n >= 30000), 64'd0);
      repeat (4) tick();
      snap(3, w, d, r, dc);
      chk("big_wr_count", 64'(w - w0), 64'd1200);
      chk("big_done_count", 64'(d - d0), 64'd1);
      chk("big_frame_cycles", 64'(dc - st + 1), 64'd21602);
      chk("big_sb_left", 64'(qsize(3)), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
